// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, well-known command and
// response bytes, and the odd-parity helper used for host-to-device frames.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        RELEASE,
        FAIL_TO,
        FAIL_NA
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_BREAK        = 8'hF0;

    // PS/2 frames carry odd parity: data bits plus parity bit has an odd count of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the asynchronous PS2_CLK/PS2_DAT pin levels into the system clock
// domain and flags falling edges of the synchronised clock line.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fe
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] dat_pipe;
    logic                   clk_prev;

    // Idle PS/2 lines float high, so the pipeline resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_pipe <= '1;
            dat_pipe <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_pipe[0] <= ps2_clk_in;
            dat_pipe[0] <= ps2_dat_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_pipe[i] <= clk_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
            clk_prev <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign clk_sync = clk_pipe[SYNC_STAGES-1];
    assign dat_sync = dat_pipe[SYNC_STAGES-1];
    assign clk_fe   = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_command_sender.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocks out one
// command byte under device control, checks the ACK and reports the outcome.
module ps2_command_sender
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000,
    parameter int SYNC_STAGES          = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_no_ack,
    output logic       error_timed_out
);

    localparam int MAX_TO     = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                                START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // INHIBIT_CYCLES must be at least 2 so the start bit can be set on the last inhibit cycle.
    localparam logic [CNT_W-1:0] INHIBIT_LAST    = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INHIBIT_PRELAST = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] START_LIMIT     = CNT_W'(START_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] XFER_LIMIT      = CNT_W'(XFER_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX         = '1;

    ps2_tx_state_t    state;
    logic [7:0]       cmd_q;
    logic             parity_q;
    logic [3:0]       bit_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             clk_sync;
    logic             dat_sync;
    logic             clk_fe;
    logic             pulse_now;

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk       (CLOCK_50),
        .reset     (reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .clk_sync  (clk_sync),
        .dat_sync  (dat_sync),
        .clk_fe    (clk_fe)
    );

    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign pulse_now = command_was_sent | error_no_ack | error_timed_out;

    // Request handshake: send_command is a one-cycle request, taken only in IDLE
    // outside the terminal-pulse cycle; otherwise dropped with no effect on cmd_q.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state             <= IDLE;
            cmd_q             <= '0;
            parity_q          <= 1'b0;
            bit_idx           <= '0;
            cnt               <= '0;
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            busy              <= 1'b0;
            command_was_sent  <= 1'b0;
            error_no_ack      <= 1'b0;
            error_timed_out   <= 1'b0;
        end else begin
            command_was_sent <= 1'b0;
            error_no_ack     <= 1'b0;
            error_timed_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_command && !pulse_now) begin
                        cmd_q             <= command;
                        parity_q          <= odd_parity(command);
                        busy              <= 1'b1;
                        ps2_clk_drive_low <= 1'b1;
                        cnt               <= '0;
                        state             <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    cnt <= cnt_inc;
                    if (cnt == INHIBIT_PRELAST) ps2_dat_drive_low <= 1'b1;
                    if (cnt == INHIBIT_LAST) begin
                        ps2_clk_drive_low <= 1'b0;
                        cnt               <= '0;
                        state             <= RTS;
                    end
                end
                RTS: begin
                    if (clk_fe) begin
                        ps2_dat_drive_low <= ~cmd_q[0];
                        bit_idx           <= 4'd1;
                        cnt               <= '0;
                        state             <= SEND;
                    end else if (cnt == START_LIMIT) begin
                        ps2_dat_drive_low <= 1'b0;
                        state             <= FAIL_TO;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                SEND, ACK, RELEASE: begin
                    cnt <= cnt_inc;
                    if (cnt == XFER_LIMIT) begin
                        ps2_dat_drive_low <= 1'b0;
                        state             <= FAIL_TO;
                    end else if (state == SEND) begin
                        if (clk_fe) begin
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx <= 4'd7) begin
                                ps2_dat_drive_low <= ~cmd_q[bit_idx[2:0]];
                            end else if (bit_idx == 4'd8) begin
                                ps2_dat_drive_low <= ~parity_q;
                            end else begin
                                ps2_dat_drive_low <= 1'b0;
                                state             <= ACK;
                            end
                        end
                    end else if (state == ACK) begin
                        // Any falling edge after the stop bit is taken as the ACK clock.
                        if (clk_fe) state <= dat_sync ? FAIL_NA : RELEASE;
                    end else begin
                        if (clk_sync && dat_sync) begin
                            command_was_sent <= 1'b1;
                            busy             <= 1'b0;
                            state            <= IDLE;
                        end
                    end
                end
                FAIL_TO: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    error_timed_out   <= 1'b1;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                FAIL_NA: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    error_no_ack      <= 1'b1;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_sender.sv
// Bench for ps2_command_sender: a behavioural PS/2 device drives the shared
// open-drain lines; a per-cycle compare process checks outcomes and busy.
module tb_ps2_command_sender;
    import ps2_pkg::*;

    localparam int N_INH   = 200;
    localparam int T_START = 3000;
    localparam int X_XFER  = 2000;
    localparam int HALF    = 40;

    localparam logic [1:0] OUT_SENT = 2'd1;
    localparam logic [1:0] OUT_NA   = 2'd2;
    localparam logic [1:0] OUT_TO   = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] command = 8'h00;
    logic       send_command = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_pin;
    logic       ps2_dat_pin;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       busy;
    logic       command_was_sent;
    logic       error_no_ack;
    logic       error_timed_out;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         last_pulse_cyc = 0;
    int         lo_run = 0;
    logic       model_busy = 1'b0;
    logic [1:0] exp_q[$];
    logic [9:0] rx;
    int         first_fall;

    assign ps2_clk_pin = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_dat_pin = ~(ps2_dat_drive_low | dev_dat_low);

    ps2_command_sender #(
        .INHIBIT_CYCLES      (N_INH),
        .START_TIMEOUT_CYCLES(T_START),
        .XFER_TIMEOUT_CYCLES (X_XFER),
        .SYNC_STAGES         (2)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (reset),
        .command          (command),
        .send_command     (send_command),
        .ps2_clk_in       (ps2_clk_pin),
        .ps2_dat_in       (ps2_dat_pin),
        .ps2_clk_drive_low(ps2_clk_drive_low),
        .ps2_dat_drive_low(ps2_dat_drive_low),
        .busy             (busy),
        .command_was_sent (command_was_sent),
        .error_no_ack     (error_no_ack),
        .error_timed_out  (error_timed_out)
    );

    // Clock/reset block
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Device-side view of a frame: bits 0..7 data LSB first, bit 8 odd parity, bit 9 stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    // Scoreboard / compare process
    always @(negedge clk) begin
        if (!reset) begin
            logic [2:0] pulses;
            logic [1:0] got;
            pulses = {command_was_sent, error_no_ack, error_timed_out};
            if (pulses != 3'b000) begin
                got = command_was_sent ? OUT_SENT : (error_no_ack ? OUT_NA : OUT_TO);
                check("single_pulse", $countones(pulses), 1);
                if (exp_q.size() == 0) check("outcome_unexpected", got, 0);
                else check("outcome", got, exp_q.pop_front());
                check("busy_at_pulse", busy, 0);
                last_pulse_cyc = cyc;
                model_busy     = 1'b0;
            end else begin
                check("busy", busy, model_busy);
                if (!model_busy) check("idle_lines", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);
            end
            if (ps2_clk_drive_low) lo_run++;
            else if (lo_run != 0) begin
                check("inhibit_len", lo_run, N_INH);
                lo_run = 0;
            end
        end
    end

    // Driver tasks
    task automatic send_cmd(input logic [7:0] b, input bit accepted);
        @(negedge clk);
        command      = b;
        send_command = 1'b1;
        @(posedge clk);
        #1;
        send_command = 1'b0;
        command      = ~b;
        if (accepted) begin
            accept_cyc = cyc;
            model_busy = 1'b1;
        end
    endtask

    task automatic device_run(input int n_clocks, input logic ack,
                              output logic [9:0] rx_bits, output int fall_cyc);
        int guard;
        guard    = 0;
        rx_bits  = '0;
        fall_cyc = 0;
        while (!(ps2_clk_drive_low == 1'b0 && ps2_dat_drive_low == 1'b1) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("rts_seen", guard < 20000, 1);
        repeat (20) @(negedge clk);
        for (int i = 0; i < n_clocks; i++) begin
            if (i == 10) begin
                dev_dat_low = ack;
                repeat (5) @(negedge clk);
            end
            if (i == 0) fall_cyc = cyc;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 10) rx_bits[i] = ps2_dat_pin;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int g;
        g = 0;
        while (model_busy && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("finish_in_budget", model_busy, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int d;
        check("model_frame_ed", frame_of(8'hED), 10'h3ED);
        check("model_frame_f4", frame_of(8'hF4), 10'h2F4);
        check("model_frame_00", frame_of(8'h00), 10'h300);
        check("model_frame_ff", frame_of(8'hFF), 10'h3FF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {ps2_clk_drive_low, ps2_dat_drive_low, busy,
                              command_was_sent, error_no_ack, error_timed_out}, 0);
        check("rst_state", dut.state, IDLE);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Successful sends: set LEDs, enable scanning, all-zero byte
        exp_q.push_back(OUT_SENT);
        send_cmd(PS2_CMD_SET_LEDS, 1);
        device_run(11, 1'b1, rx, first_fall);
        check("frame_ed", rx, frame_of(8'hED));
        wait_idle(500);

        exp_q.push_back(OUT_SENT);
        send_cmd(PS2_CMD_ENABLE, 1);
        device_run(11, 1'b1, rx, first_fall);
        check("frame_f4", rx, frame_of(8'hF4));
        wait_idle(500);

        exp_q.push_back(OUT_SENT);
        send_cmd(8'h00, 1);
        device_run(11, 1'b1, rx, first_fall);
        check("frame_00", rx, frame_of(8'h00));
        wait_idle(500);

        // Device never clocks
        exp_q.push_back(OUT_TO);
        send_cmd(PS2_CMD_ENABLE, 1);
        wait_idle(N_INH + T_START + 100);
        d = last_pulse_cyc - accept_cyc;
        check("start_to_time", (d >= N_INH + T_START - 2) && (d <= N_INH + T_START + 2), 1);
        check("start_to_lines", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);

        // Device clocks 11 times but never ACKs
        exp_q.push_back(OUT_NA);
        send_cmd(PS2_CMD_RESET, 1);
        device_run(11, 1'b0, rx, first_fall);
        check("frame_ff", rx, frame_of(8'hFF));
        wait_idle(500);

        // Device stops after 5 clocks
        exp_q.push_back(OUT_TO);
        send_cmd(PS2_CMD_SET_LEDS, 1);
        device_run(5, 1'b1, rx, first_fall);
        wait_idle(X_XFER + 500);
        d = last_pulse_cyc - first_fall;
        check("xfer_to_time", (d >= X_XFER) && (d <= X_XFER + 6), 1);
        check("xfer_to_lines", {ps2_clk_drive_low, ps2_dat_drive_low}, 0);

        // Request while busy is dropped
        exp_q.push_back(OUT_SENT);
        send_cmd(PS2_CMD_SET_LEDS, 1);
        fork
            device_run(11, 1'b1, rx, first_fall);
            begin
                repeat (N_INH + 300) @(negedge clk);
                send_cmd(8'h55, 0);
            end
        join
        check("frame_overlap", rx, frame_of(8'hED));
        wait_idle(500);

        // Reset in the middle of SEND aborts silently
        send_cmd(PS2_CMD_ENABLE, 1);
        device_run(4, 1'b1, rx, first_fall);
        repeat (10) @(negedge clk);
        reset      = 1'b1;
        model_busy = 1'b0;
        @(negedge clk);
        check("abort_outputs", {ps2_clk_drive_low, ps2_dat_drive_low, busy,
                                command_was_sent, error_no_ack, error_timed_out}, 0);
        check("abort_state", dut.state, IDLE);
        reset = 1'b0;
        repeat (X_XFER + 200) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_command_sender.md
Name: ps2_command_sender

Overview:
Host-to-device PS/2 transmitter. It sends one command byte, for example 0xED (set LEDs) or 0xF4 (enable scanning), from the FPGA to the keyboard. It sits beside the existing PS/2 receive path and shares the same PS2_CLK/PS2_DAT pins through open-drain drive-low controls in the top level. It performs the full inhibit, request-to-send, 11-clock exchange and ACK check, and reports success, missing ACK or timeout.

Parameters:
INHIBIT_CYCLES, 5000, cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
START_TIMEOUT_CYCLES, 750000, maximum cycles from clock release to the first device falling edge (15 ms).
XFER_TIMEOUT_CYCLES, 100000, maximum cycles from the first falling edge to line release (2 ms).
SYNC_STAGES, 2, flip-flop stages on ps2_clk_in and ps2_dat_in.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high reset.
command  in  8  byte to send; sampled when a send is accepted.
send_command  in  1  request pulse; ignored while busy=1.
ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
ps2_clk_drive_low  out  1  1 = top level drives PS2_CLK to 0; otherwise high-Z.
ps2_dat_drive_low  out  1  1 = top level drives PS2_DAT to 0; otherwise high-Z.
busy  out  1  high from acceptance until the terminal pulse.
command_was_sent  out  1  one-cycle pulse; byte sent and ACK received.
error_no_ack  out  1  one-cycle pulse; device left DAT high at the ACK clock.
error_timed_out  out  1  one-cycle pulse; a timeout expired.

Behaviour:
- Reset: state IDLE. Every output is 0 and both lines are released on the cycle after reset is sampled. Reset in any state aborts the transfer and emits no pulse.
- Input conditioning: both inputs pass through SYNC_STAGES flip-flops.
  - A falling edge ("fe") is synced clk previous=1 and current=0.
  - Total latency from pin to fe is SYNC_STAGES+1 cycles.
- IDLE:
  - send_command=1 latches command.
  - The cycle it is accepted, parity = ~^command (odd parity).
  - The cycle after acceptance: busy=1, go to INHIBIT.
- INHIBIT:
  - clk_drive_low=1 and the counter counts INHIBIT_CYCLES.
  - On the last cycle, dat_drive_low is also set to 1 (start bit).
  - Go to RTS.
- RTS:
  - clk_drive_low=0, dat_drive_low=1, and the timeout counter restarts.
  - First fe: drive bit0 (drive_low = ~bit), bit_idx=1, restart the counter, go to SEND.
  - Counter reaches START_TIMEOUT_CYCLES: go to FAIL_TO.
- SEND: on each fe, drive the next bit.
  - Bits 1..7 are data, LSB first.
  - Fe 9 drives parity.
  - Fe 10 drives the stop bit: dat_drive_low=0, then go to ACK.
  - Bits change only on fe; the device samples on the rising edge.
- ACK:
  - On fe 11, sample synced DAT.
  - DAT=0 goes to RELEASE; DAT=1 goes to FAIL_NA.
- RELEASE: wait for synced CLK=1 and DAT=1 on the same cycle, then pulse command_was_sent and go to IDLE.
- Transfer timeout:
  - The counter runs continuously through SEND, ACK and RELEASE.
  - Reaching XFER_TIMEOUT_CYCLES goes to FAIL_TO.
- FAIL_TO / FAIL_NA:
  - Both lines are released.
  - The matching error pulse is emitted for one cycle, then go to IDLE.
- busy falls on the same cycle as the terminal pulse. A new send_command is accepted on the following cycle.
- send_command while busy is dropped, not queued; the latched command is unchanged.
- Only one terminal pulse is ever emitted per accepted command.
- Counter width is $clog2(max(START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES, INHIBIT_CYCLES)+1) bits. The counter saturates and never wraps.
- An fe in INHIBIT or IDLE is ignored.
- A glitch producing an extra fe after the stop bit is treated as the ACK clock.

Decomposition:
- Shared package ps2_pkg:
  - state encoding: IDLE, INHIBIT, RTS, SEND, ACK, RELEASE, FAIL_TO, FAIL_NA.
  - command constants: PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF.
  - response constants: PS2_RSP_ACK=8'hFA, PS2_BREAK=8'hF0.
- One sub-module, ps2_line_sync: SYNC_STAGES synchronizers for CLK and DAT, plus falling-edge detect on CLK. The receive path may reuse it.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that ACKs.
  - clk_drive_low is held for exactly 5000 cycles.
  - Device receives bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - One command_was_sent pulse after the lines go high; busy is 1 throughout.
- Send 0xF4 and 0x00.
  - 0xF4 gives parity 0; 0x00 gives parity 1.
  - Both give command_was_sent.
- Device never clocks: exactly one error_timed_out at 5000+750000 cycles (±2) after acceptance. Both drive_low are 0 afterwards.
- Device clocks 11 times but leaves DAT high at fe 11: exactly one error_no_ack pulse; command_was_sent stays 0.
- Device stops after 5 clocks: one error_timed_out 100000 cycles after the first fe.
- Overlap and reset:
  - Pulse send_command with 0x55 mid-transfer of 0xED: the device still receives 0xED.
  - Then assert reset during SEND: next cycle both drive_low, busy and all pulses are 0, and state is IDLE.
